midi_phase_inc_engine: RTL and testbench
========================================

MIDI_PHASE_INC_ENGINE -- requirements
Module: midi_phase_inc_engine

Interface
REQ-001 SHALL have parameter NUMCH, default 8: number of channel phase-increment registers (1..64).
REQ-002 SHALL have parameter PI_W, default 32: phase-increment width.
REQ-003 SHALL have parameter FRAC_W, default 8: semitone fine-tune fraction width.
REQ-004 SHALL have parameter ROMFILE, default "./inferredMem/semitoneTop.txt": hex file of 13 top-octave increments (notes 120..132).
REQ-005 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  engine can accept; high only in IDLE.
REQ-009 SHALL have port req_chan  in  $clog2(NUMCH) (min 1)  target channel.
REQ-010 SHALL have port req_note  in  7  MIDI note number 0..127.
REQ-011 SHALL have port req_frac  in  FRAC_W  unsigned fraction toward note+1.
REQ-012 SHALL have port req_off  in  1  note-off: force the channel increment to 0.
REQ-013 SHALL have port phase_increments  out  NUMCH x PI_W  registered per-channel increments.
REQ-014 SHALL have port done  out  1  one-cycle pulse, result written.
REQ-015 SHALL have port done_chan  out  $clog2(NUMCH)  channel of the last write.
REQ-016 SHALL have port err  out  1  one-cycle pulse, req_chan >= NUMCH.

Function
REQ-017 SHALL accept a request on a rising edge with req_valid and req_ready both high; inputs are captured at that edge and may change afterward.
REQ-018 SHALL use FSM IDLE -> SPLIT -> LOOKUP -> INTERP -> WRITE -> IDLE, one cycle per state.
REQ-019 SHALL, with req_off=1, go IDLE -> WRITE and write 0.
REQ-020 SPLIT SHALL register oct = note/12 (0..10) and semi = note%12.
REQ-021 LOOKUP SHALL register a = BASE[semi] >> (10-oct) and b = BASE[semi+1] >> (10-oct).
REQ-022 INTERP SHALL register r = a + (((b-a) * frac) >> FRAC_W) with a full-width product (PI_W+FRAC_W bits); the result never exceeds b and never wraps.
REQ-023 On the edge leaving WRITE, phase_increments[chan] SHALL load r (or 0); all other channels are unchanged.
REQ-024 For an edge-k acceptance, the new value and done=1 SHALL be visible in the cycle after edge k+4 (edge k+1 for note-off).
REQ-025 done_chan SHALL take the written channel at the same time as done.
REQ-026 req_ready SHALL return high in that same cycle, so the next acceptance can occur no earlier than that cycle's edge.
REQ-027 If req_chan >= NUMCH, the request SHALL be accepted, no register written, done kept low, and err pulsed at the time done would have pulsed.
REQ-028 If req_frac=0, the result SHALL equal a exactly.
REQ-029 Note 127 SHALL use BASE[7] and BASE[8] with shift 0.
REQ-030 Note 0 SHALL use shift 10.
REQ-031 req_valid SHALL be ignored while not IDLE; no queuing.

Reset
REQ-032 reset_n low SHALL asynchronously force: state IDLE, all phase_increments 0, done 0, err 0, done_chan 0, and all pipeline registers 0.
REQ-033 Immediately after reset deassertion, req_ready SHALL be 1.
REQ-034 Reset mid-operation SHALL abort the request with no write and no done.
REQ-035 The ROM contents SHALL be unaffected by reset.

Structure
REQ-036 Package midi_pi_pkg SHALL hold the state enum, NOTE_W=7, TOP_OCT=10, SEMIS=12 and the ROM depth constant 13.
REQ-037 Sub-module midi_semitone_rom SHALL hold the 13 x PI_W table, initialised from ROMFILE, with two registered read ports used in LOOKUP.
REQ-038 The 13-entry ROM SHALL replace the former 128-entry note table.

Verification
REQ-039 Scenario: reset, then chan 2, note 69, frac 0 -> phase_increments[2] = BASE[9]>>5; done with done_chan=2 exactly 5 cycles after the accept edge; other channels 0.
REQ-040 Scenario: chan 0, note 60, frac 128 -> value = (BASE[0]>>5) + (((BASE[1]>>5) - (BASE[0]>>5)) * 128 >> 8).
REQ-041 Scenario: note 127, frac 255 and note 0, frac 0 -> matches REQ-029 and REQ-030 arithmetic; no overflow.
REQ-042 Scenario: note-off on a written chan 3 -> value 0, done in the cycle after edge k+1; req_valid held high during busy -> only one write per IDLE acceptance.
REQ-043 Scenario: NUMCH=6, req_chan 7 -> err pulse, no register change, done low.
REQ-044 Scenario: reset_n pulsed low during INTERP -> all outputs 0 at once, no done, req_ready high after release.

Source files
------------

// File: rtl/midi_pi_pkg.sv
// Shared constants, FSM states and top-octave increment table
// for the MIDI phase-increment engine.
package midi_pi_pkg;

    localparam int NOTE_W    = 7;
    localparam int TOP_OCT   = 10;
    localparam int SEMIS     = 12;
    localparam int ROM_DEPTH = 13;
    localparam int ROM_AW    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPLIT,
        S_LOOKUP,
        S_INTERP,
        S_WRITE
    } state_t;

    // Notes 120..132, equal-tempered, scaled so note 132 is 2^31
    function automatic logic [31:0] base_entry(input int idx);
        case (idx)
            0:       return 32'h4000_0000;
            1:       return 32'h43D0_0000;
            2:       return 32'h47D0_0000;
            3:       return 32'h4C20_0000;
            4:       return 32'h50A0_0000;
            5:       return 32'h5570_0000;
            6:       return 32'h5A80_0000;
            7:       return 32'h5FE0_0000;
            8:       return 32'h6590_0000;
            9:       return 32'h6BA0_0000;
            10:      return 32'h7210_0000;
            11:      return 32'h78D0_0000;
            12:      return 32'h8000_0000;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/midi_semitone_rom.sv
// 13-entry top-octave increment table with two registered
// read ports; the contents themselves are constant.
module midi_semitone_rom
    import midi_pi_pkg::*;
#(
    parameter int    PI_W    = 32,
    parameter string ROMFILE = "./inferredMem/semitoneTop.txt"
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [ROM_AW-1:0] addr_a,
    input  logic [ROM_AW-1:0] addr_b,
    output logic [PI_W-1:0]   q_a,
    output logic [PI_W-1:0]   q_b
);

    // An empty table name builds a blank (all-zero) table
    localparam bit BLANK = (ROMFILE == "");

    logic [PI_W-1:0] mem [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_tab
        assign mem[i] = BLANK ? '0 : PI_W'(base_entry(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_a <= '0;
            q_b <= '0;
        end else if (en) begin
            q_a <= mem[addr_a];
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/midi_phase_inc_engine.sv
// Converts (channel, note, fine fraction) requests into per-channel
// oscillator phase increments through a 4-stage multi-cycle FSM.
module midi_phase_inc_engine
    import midi_pi_pkg::*;
#(
    parameter int    NUMCH   = 8,
    parameter int    PI_W    = 32,
    parameter int    FRAC_W  = 8,
    parameter string ROMFILE = "./inferredMem/semitoneTop.txt",
    localparam int   CH_W    = (NUMCH > 1) ? $clog2(NUMCH) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [CH_W-1:0]             req_chan,
    input  logic [NOTE_W-1:0]           req_note,
    input  logic [FRAC_W-1:0]           req_frac,
    input  logic                        req_off,
    output logic [NUMCH-1:0][PI_W-1:0]  phase_increments,
    output logic                        done,
    output logic [CH_W-1:0]             done_chan,
    output logic                        err
);

    localparam int PW = PI_W + FRAC_W;

    state_t state, state_nx;

    logic [CH_W-1:0]   chan_q;
    logic [NOTE_W-1:0] note_q;
    logic [FRAC_W-1:0] frac_q;
    logic              off_q;
    logic              bad_q;
    logic [3:0]        oct_q;
    logic [3:0]        semi_q;
    logic [3:0]        shamt;
    logic [PI_W-1:0]   base_a, base_b;
    logic [PI_W-1:0]   a_sh, b_sh;
    logic [PI_W-1:0]   r_q, r_nx;
    logic [PW-1:0]     prod;
    logic              accept;
    logic              req_bad;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_bad   = ({1'b0, req_chan} >= (CH_W+1)'(NUMCH));

    midi_semitone_rom #(
        .PI_W    (PI_W),
        .ROMFILE (ROMFILE)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state == S_LOOKUP),
        .addr_a  (semi_q),
        .addr_b  (semi_q + 4'd1),
        .q_a     (base_a),
        .q_b     (base_b)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (req_valid) state_nx = req_off ? S_WRITE : S_SPLIT;
            S_SPLIT:  state_nx = S_LOOKUP;
            S_LOOKUP: state_nx = S_INTERP;
            S_INTERP: state_nx = S_WRITE;
            S_WRITE:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // b >= a always, so the full-width product keeps r within [a, b]
    assign shamt = 4'(TOP_OCT) - oct_q;
    assign a_sh  = base_a >> shamt;
    assign b_sh  = base_b >> shamt;
    assign prod  = PW'(b_sh - a_sh) * PW'(frac_q);
    assign r_nx  = a_sh + PI_W'(prod >> FRAC_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            chan_q           <= '0;
            note_q           <= '0;
            frac_q           <= '0;
            off_q            <= 1'b0;
            bad_q            <= 1'b0;
            oct_q            <= '0;
            semi_q           <= '0;
            r_q              <= '0;
            phase_increments <= '0;
            done             <= 1'b0;
            done_chan        <= '0;
            err              <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            err   <= 1'b0;
            if (accept) begin
                chan_q <= req_chan;
                note_q <= req_note;
                frac_q <= req_frac;
                off_q  <= req_off;
                bad_q  <= req_bad;
            end
            if (state == S_SPLIT) begin
                oct_q  <= 4'(note_q / 7'(SEMIS));
                semi_q <= 4'(note_q % 7'(SEMIS));
            end
            if (state == S_INTERP) r_q <= r_nx;
            if (state == S_WRITE) begin
                err  <= bad_q;
                done <= !bad_q;
                if (!bad_q) begin
                    done_chan <= chan_q;
                    for (int i = 0; i < NUMCH; i++) begin
                        if (CH_W'(i) == chan_q)
                            phase_increments[i] <= off_q ? '0 : r_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_phase_inc_engine.sv
// Scoreboard bench: directed requests push expected writes,
// a negedge monitor checks each done/err against them.
module tb_midi_phase_inc_engine;

    localparam int NUMCH = 6;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [2:0]             req_chan = '0;
    logic [6:0]             req_note = '0;
    logic [7:0]             req_frac = '0;
    logic                   req_off = 1'b0;
    logic [NUMCH-1:0][31:0] phase_increments;
    logic                   done;
    logic [2:0]             done_chan;
    logic                   err;

    midi_phase_inc_engine #(
        .NUMCH  (NUMCH),
        .PI_W   (32),
        .FRAC_W (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_chan         (req_chan),
        .req_note         (req_note),
        .req_frac         (req_frac),
        .req_off          (req_off),
        .phase_increments (phase_increments),
        .done             (done),
        .done_chan        (done_chan),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  chan;
        logic        is_err;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] shadow [NUMCH];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && (done || err)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected: done=%0b err=%0b chan=%0d",
                         done, err, done_chan);
            end else begin
                e = sb.pop_front();
                chk("flags", {62'd0, done, err},
                    e.is_err ? 64'd1 : 64'd2);
                chk("latency", 64'(cyc), 64'(e.due));
                if (!e.is_err) begin
                    chk("done_chan", 64'(done_chan), 64'(e.chan));
                    shadow[e.chan] = e.val;
                end
                for (int i = 0; i < NUMCH; i++)
                    chk($sformatf("pi[%0d]", i),
                        64'(phase_increments[i]), 64'(shadow[i]));
            end
        end
    end

    task automatic send(input logic [2:0] ch, input logic [6:0] nt,
                        input logic [7:0] fr, input logic off,
                        input int hold, input logic ex_err,
                        input logic [31:0] ex_val, input bit push);
        int k;
        bit got;
        k = 0;
        got = 1'b0;
        req_chan  = ch;
        req_note  = nt;
        req_frac  = fr;
        req_off   = off;
        req_valid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk);
            if (req_ready) begin
                got = 1'b1;
                k = cyc;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: chan=%0d note=%0d", ch, nt);
        end else if (push) begin
            sb.push_back('{chan: ch, is_err: ex_err, val: ex_val,
                           due: k + (off ? 2 : 5)});
        end
        repeat (hold) @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_chan  = 3'($urandom);
        req_note  = 7'($urandom);
        req_frac  = 8'($urandom);
        req_off   = 1'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        chk("drained", 64'(sb.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pi"}, 64'(phase_increments == '0), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_done_chan"}, 64'(done_chan), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NUMCH; i++) shadow[i] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_idle_outputs("reset");
        chk("reset_ready", 64'(req_ready), 64'd1);

        send(3'd2, 7'd69, 8'd0, 1'b0, 0, 1'b0, 32'h035D_0000, 1'b1);
        send(3'd0, 7'd60, 8'd128, 1'b0, 0, 1'b0, 32'h020F_4000, 1'b1);
        send(3'd1, 7'd127, 8'd255, 1'b0, 0, 1'b0, 32'h658A_5000, 1'b1);
        send(3'd4, 7'd0, 8'd0, 1'b0, 0, 1'b0, 32'h0010_0000, 1'b1);
        send(3'd5, 7'd11, 8'd255, 1'b0, 0, 1'b0, 32'h001F_FE34, 1'b1);
        send(3'd3, 7'd60, 8'd0, 1'b0, 0, 1'b0, 32'h0200_0000, 1'b1);
        send(3'd3, 7'd64, 8'd77, 1'b1, 0, 1'b0, 32'h0, 1'b1);
        drain();

        send(3'd4, 7'd69, 8'd0, 1'b0, 3, 1'b0, 32'h035D_0000, 1'b1);
        drain();

        send(3'd7, 7'd60, 8'd10, 1'b0, 0, 1'b1, 32'h0, 1'b1);
        send(3'd6, 7'd60, 8'd0, 1'b1, 0, 1'b1, 32'h0, 1'b1);
        drain();

        send(3'd1, 7'd64, 8'd50, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        for (int i = 0; i < NUMCH; i++) shadow[i] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midreset_ready", 64'(req_ready), 64'd1);
        repeat (8) @(negedge clk);
        chk_idle_outputs("after_abort");

        send(3'd2, 7'd127, 8'd0, 1'b0, 0, 1'b0, 32'h5FE0_0000, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
